rs_param: RTL and testbench

Parametrised reservation station, the successor to the fixed per-FU RS entries instantiated inside `dispatch`. It buffers up to `DEPTH` renamed micro-ops for one functional unit and wakes their source operands from `NUM_CDB` parallel result-broadcast ports. Each cycle it issues the oldest ready micro-op, oldest by dispatch order, to the execution unit under a valid/ready handshake, and it supports a full pipeline flush. One instance sits between `dispatch` and each of the ALU/LSU/BRU execution units.

---
 rtl/rs_param.sv | 165 ++++++++++++++++
 tb/tb_rs_param.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_param.sv
// Parametrised reservation station: buffers renamed micro-ops for one functional unit,
// wakes sources from NUM_CDB broadcast ports and issues the oldest ready op.
module rs_param #(
    parameter int DEPTH     = 8,
    parameter int NUM_CDB   = 2,
    parameter int PREG_W    = 7,
    parameter int ROB_TAG_W = 4,
    parameter int PAYLOAD_W = 96,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    input  logic                        disp_valid_i,
    output logic                        disp_ready_o,
    input  logic [PAYLOAD_W-1:0]        disp_payload_i,
    input  logic [ROB_TAG_W-1:0]        disp_rob_tag_i,
    input  logic [PREG_W-1:0]           disp_rs1_tag_i,
    input  logic [PREG_W-1:0]           disp_rs2_tag_i,
    input  logic                        disp_rs1_ready_i,
    input  logic                        disp_rs2_ready_i,
    input  logic [NUM_CDB-1:0]          cdb_valid_i,
    input  logic [NUM_CDB*PREG_W-1:0]   cdb_tag_i,
    output logic                        issue_valid_o,
    input  logic                        issue_ready_i,
    output logic [PAYLOAD_W-1:0]        issue_payload_o,
    output logic [ROB_TAG_W-1:0]        issue_rob_tag_o,
    output logic [PREG_W-1:0]           issue_rs1_tag_o,
    output logic [PREG_W-1:0]           issue_rs2_tag_o,
    output logic [CNT_W-1:0]            count_o
);

    logic [DEPTH-1:0]     valid_q, valid_d, rs1_rdy_q, rs1_rdy_d, rs2_rdy_q, rs2_rdy_d;
    logic [PREG_W-1:0]    rs1_tag_q [DEPTH];
    logic [PREG_W-1:0]    rs1_tag_d [DEPTH];
    logic [PREG_W-1:0]    rs2_tag_q [DEPTH];
    logic [PREG_W-1:0]    rs2_tag_d [DEPTH];
    logic [ROB_TAG_W-1:0] rob_q [DEPTH];
    logic [ROB_TAG_W-1:0] rob_d [DEPTH];
    logic [PAYLOAD_W-1:0] pay_q [DEPTH];
    logic [PAYLOAD_W-1:0] pay_d [DEPTH];
    // older_q[i][j] set means entry i was dispatched before entry j
    logic [DEPTH-1:0]     older_q [DEPTH];
    logic [DEPTH-1:0]     older_d [DEPTH];
    logic [CNT_W-1:0]     count_q, count_d;

    logic [DEPTH-1:0]     cand_s, blk_s, sel_s, wr_oh_s;
    logic                 found_s, disp_fire_s, issue_fire_s;

    function automatic logic cdb_hit(input logic [PREG_W-1:0]         tag,
                                     input logic [NUM_CDB-1:0]        vld,
                                     input logic [NUM_CDB*PREG_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) begin
            hit = hit | (vld[k] && (tags[k*PREG_W +: PREG_W] == tag));
        end
        return hit;
    endfunction

    // Oldest-ready select: a candidate is blocked by any older candidate
    always_comb begin
        cand_s = valid_q & rs1_rdy_q & rs2_rdy_q;
        blk_s  = '0;
        sel_s  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                blk_s[i] = blk_s[i] | ((i != j) && cand_s[j] && older_q[j][i]);
            end
            sel_s[i] = cand_s[i] & ~blk_s[i];
        end
    end

    // Issue mux, handshakes and lowest-free slot pick
    always_comb begin
        disp_ready_o    = (count_q != CNT_W'(DEPTH));
        issue_valid_o   = (|cand_s) && !flush_i && !rst;
        issue_fire_s    = issue_valid_o && issue_ready_i;
        disp_fire_s     = disp_valid_i && disp_ready_o && !flush_i;
        count_o         = count_q;
        issue_payload_o = '0;
        issue_rob_tag_o = '0;
        issue_rs1_tag_o = '0;
        issue_rs2_tag_o = '0;
        found_s         = 1'b0;
        wr_oh_s         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            issue_payload_o = issue_payload_o | (pay_q[i]     & {PAYLOAD_W{sel_s[i]}});
            issue_rob_tag_o = issue_rob_tag_o | (rob_q[i]     & {ROB_TAG_W{sel_s[i]}});
            issue_rs1_tag_o = issue_rs1_tag_o | (rs1_tag_q[i] & {PREG_W{sel_s[i]}});
            issue_rs2_tag_o = issue_rs2_tag_o | (rs2_tag_q[i] & {PREG_W{sel_s[i]}});
            wr_oh_s[i]      = !valid_q[i] && !found_s;
            found_s         = found_s | !valid_q[i];
        end
    end

    // Entry next-state: dispatch write with bypass, wakeup, issue free, flush
    always_comb begin
        valid_d   = valid_q;
        rs1_rdy_d = rs1_rdy_q;
        rs2_rdy_d = rs2_rdy_q;
        rs1_tag_d = rs1_tag_q;
        rs2_tag_d = rs2_tag_q;
        rob_d     = rob_q;
        pay_d     = pay_q;
        older_d   = older_q;
        count_d   = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (disp_fire_s && wr_oh_s[i]) begin
                valid_d[i]   = 1'b1;
                rs1_rdy_d[i] = disp_rs1_ready_i | cdb_hit(disp_rs1_tag_i, cdb_valid_i, cdb_tag_i);
                rs2_rdy_d[i] = disp_rs2_ready_i | cdb_hit(disp_rs2_tag_i, cdb_valid_i, cdb_tag_i);
                rs1_tag_d[i] = disp_rs1_tag_i;
                rs2_tag_d[i] = disp_rs2_tag_i;
                rob_d[i]     = disp_rob_tag_i;
                pay_d[i]     = disp_payload_i;
            end else begin
                valid_d[i]   = valid_q[i] & ~(issue_fire_s & sel_s[i]);
                rs1_rdy_d[i] = rs1_rdy_q[i] | cdb_hit(rs1_tag_q[i], cdb_valid_i, cdb_tag_i);
                rs2_rdy_d[i] = rs2_rdy_q[i] | cdb_hit(rs2_tag_q[i], cdb_valid_i, cdb_tag_i);
                rs1_tag_d[i] = rs1_tag_q[i];
                rs2_tag_d[i] = rs2_tag_q[i];
                rob_d[i]     = rob_q[i];
                pay_d[i]     = pay_q[i];
            end
            for (int j = 0; j < DEPTH; j++) begin
                older_d[i][j] = (disp_fire_s && wr_oh_s[j]) ? (i != j) :
                                ((disp_fire_s && wr_oh_s[i]) ? 1'b0 : older_q[i][j]);
            end
        end
        if (flush_i) begin
            valid_d = '0;
            count_d = '0;
        end else begin
            case ({disp_fire_s, issue_fire_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Entry contents and age matrix; only meaningful where valid_q is set
    always_ff @(posedge clk) begin
        rs1_rdy_q <= rs1_rdy_d;
        rs2_rdy_q <= rs2_rdy_d;
        rs1_tag_q <= rs1_tag_d;
        rs2_tag_q <= rs2_tag_d;
        rob_q     <= rob_d;
        pay_q     <= pay_d;
        older_q   <= older_d;
    end

endmodule

// File: tb/tb_rs_param.sv
// Directed bench for rs_param: per-cycle vector table plus hand-written fill, age-wrap,
// flush and reset sequences.
module tb_rs_param;
    localparam int DEPTH = 8, NUM_CDB = 2, PREG_W = 7, ROB_TAG_W = 4, PAYLOAD_W = 96, CNT_W = 4;

    logic                      clk = 1'b0;
    logic                      rst, flush_i, disp_valid_i, disp_ready_o;
    logic [PAYLOAD_W-1:0]      disp_payload_i, issue_payload_o;
    logic [ROB_TAG_W-1:0]      disp_rob_tag_i, issue_rob_tag_o;
    logic [PREG_W-1:0]         disp_rs1_tag_i, disp_rs2_tag_i, issue_rs1_tag_o, issue_rs2_tag_o;
    logic                      disp_rs1_ready_i, disp_rs2_ready_i, issue_valid_o, issue_ready_i;
    logic [NUM_CDB-1:0]        cdb_valid_i;
    logic [NUM_CDB*PREG_W-1:0] cdb_tag_i;
    logic [CNT_W-1:0]          count_o;

    rs_param #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .PREG_W(PREG_W), .ROB_TAG_W(ROB_TAG_W),
               .PAYLOAD_W(PAYLOAD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
        .disp_payload_i(disp_payload_i), .disp_rob_tag_i(disp_rob_tag_i),
        .disp_rs1_tag_i(disp_rs1_tag_i), .disp_rs2_tag_i(disp_rs2_tag_i),
        .disp_rs1_ready_i(disp_rs1_ready_i), .disp_rs2_ready_i(disp_rs2_ready_i),
        .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
        .issue_payload_o(issue_payload_o), .issue_rob_tag_o(issue_rob_tag_o),
        .issue_rs1_tag_o(issue_rs1_tag_o), .issue_rs2_tag_o(issue_rs2_tag_o),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, flush, dv;
        logic [3:0] rob;
        logic [6:0] t1;
        logic       r1;
        logic [6:0] t2;
        logic       r2;
        logic [1:0] cv;
        logic [6:0] c0, c1;
        logic       ir;
        logic       e_dr, e_iv;
        logic [3:0] e_rob, e_cnt;
    } vec_t;

    vec_t vecs [$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t v(int rs, int fl, int dv, int rob, int t1, int r1, int t2, int r2,
                               int cv, int c0, int c1, int ir, int edr, int eiv, int erob, int ecnt);
        vec_t x;
        x.rst = 1'(rs); x.flush = 1'(fl); x.dv = 1'(dv); x.rob = 4'(rob);
        x.t1 = 7'(t1); x.r1 = 1'(r1); x.t2 = 7'(t2); x.r2 = 1'(r2);
        x.cv = 2'(cv); x.c0 = 7'(c0); x.c1 = 7'(c1); x.ir = 1'(ir);
        x.e_dr = 1'(edr); x.e_iv = 1'(eiv); x.e_rob = 4'(erob); x.e_cnt = 4'(ecnt);
        return x;
    endfunction

    function automatic logic [95:0] pay_of(input logic [3:0] r);
        logic [95:0] p;
        for (int k = 0; k < 24; k++) p[k*4 +: 4] = r;
        return p;
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        rst              = x.rst;
        flush_i          = x.flush;
        disp_valid_i     = x.dv;
        disp_rob_tag_i   = x.rob;
        disp_payload_i   = pay_of(x.rob);
        disp_rs1_tag_i   = x.t1;
        disp_rs1_ready_i = x.r1;
        disp_rs2_tag_i   = x.t2;
        disp_rs2_ready_i = x.r2;
        cdb_valid_i      = x.cv;
        cdb_tag_i        = {x.c1, x.c0};
        issue_ready_i    = x.ir;
    endtask

    task automatic check_out(input string nm, input vec_t x);
        chk({nm, "_dr"},  96'(disp_ready_o),  96'(x.e_dr));
        chk({nm, "_iv"},  96'(issue_valid_o), 96'(x.e_iv));
        chk({nm, "_cnt"}, 96'(count_o),       96'(x.e_cnt));
        if (x.e_iv) begin
            chk({nm, "_rob"}, 96'(issue_rob_tag_o), 96'(x.e_rob));
            chk({nm, "_pay"}, issue_payload_o,      pay_of(x.e_rob));
        end
    endtask

    task automatic check_reset_fields(input string nm);
        chk({nm, "_pay"}, issue_payload_o,        96'(0));
        chk({nm, "_rob"}, 96'(issue_rob_tag_o),   96'(0));
        chk({nm, "_rs1"}, 96'(issue_rs1_tag_o),   96'(0));
        chk({nm, "_rs2"}, 96'(issue_rs2_tag_o),   96'(0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t x;
        int   q [$];
        int   n;
        int   sz, acc, dv, ir;

        drive(v(1,0,0,0, 0,0,0,0, 0,0,0,0, 1,0,0,0));
        tick();
        tick();
        #1;
        check_out("reset", v(1,0,0,0, 0,0,0,0, 0,0,0,0, 1,0,0,0));
        check_reset_fields("reset");

        // basic flow: rob 0,1,2 issue back to back
        vecs.push_back(v(0,0,1,0,  0,1,0,1,  0,0,0,1,  1,0,0,0));
        vecs.push_back(v(0,0,1,1,  0,1,0,1,  0,0,0,1,  1,1,0,1));
        vecs.push_back(v(0,0,1,2,  0,1,0,1,  0,0,0,1,  1,1,1,1));
        vecs.push_back(v(0,0,0,0,  0,1,0,1,  0,0,0,1,  1,1,2,1));
        vecs.push_back(v(0,0,0,0,  0,1,0,1,  0,0,0,1,  1,0,0,0));
        // age ordering: B woken with A, C dispatched after; order A,B,C
        vecs.push_back(v(0,0,1,3, 10,0,0,1,  0,0,0,1,  1,0,0,0));
        vecs.push_back(v(0,0,1,4, 11,0,0,1,  0,0,0,1,  1,0,0,1));
        vecs.push_back(v(0,0,0,0,  0,1,0,1,  3,11,10,1, 1,0,0,2));
        vecs.push_back(v(0,0,1,5,  0,1,0,1,  0,0,0,1,  1,1,3,2));
        vecs.push_back(v(0,0,0,0,  0,1,0,1,  0,0,0,1,  1,1,4,2));
        vecs.push_back(v(0,0,0,0,  0,1,0,1,  0,0,0,1,  1,1,5,1));
        vecs.push_back(v(0,0,0,0,  0,1,0,1,  0,0,0,1,  1,0,0,0));
        // dispatch bypass, then a non-matching broadcast and a port-1 wakeup
        vecs.push_back(v(0,0,1,6,  0,1,20,0, 1,20,0,1, 1,0,0,0));
        vecs.push_back(v(0,0,0,0,  0,1,0,1,  0,0,0,1,  1,1,6,1));
        vecs.push_back(v(0,0,0,0,  0,1,0,1,  0,0,0,1,  1,0,0,0));
        vecs.push_back(v(0,0,1,7,  0,1,21,0, 1,20,0,1, 1,0,0,0));
        vecs.push_back(v(0,0,0,0,  0,1,0,1,  0,0,0,1,  1,0,0,1));
        vecs.push_back(v(0,0,0,0,  0,1,0,1,  2,0,21,1, 1,0,0,1));
        vecs.push_back(v(0,0,0,0,  0,1,0,1,  0,0,0,1,  1,1,7,1));
        vecs.push_back(v(0,0,0,0,  0,1,0,1,  0,0,0,1,  1,0,0,0));
        // backpressure: 4 ready ops held, then released
        vecs.push_back(v(0,0,1,8,  0,1,0,1,  0,0,0,0,  1,0,0,0));
        vecs.push_back(v(0,0,1,9,  0,1,0,1,  0,0,0,0,  1,1,8,1));
        vecs.push_back(v(0,0,1,10, 0,1,0,1,  0,0,0,0,  1,1,8,2));
        vecs.push_back(v(0,0,1,11, 0,1,0,1,  0,0,0,0,  1,1,8,3));
        for (int k = 0; k < 5; k++) vecs.push_back(v(0,0,0,0, 0,1,0,1, 0,0,0,0, 1,1,8,4));
        vecs.push_back(v(0,0,0,0,  0,1,0,1,  0,0,0,1,  1,1,8,4));
        vecs.push_back(v(0,0,0,0,  0,1,0,1,  0,0,0,1,  1,1,9,3));
        vecs.push_back(v(0,0,0,0,  0,1,0,1,  0,0,0,1,  1,1,10,2));
        vecs.push_back(v(0,0,0,0,  0,1,0,1,  0,0,0,1,  1,1,11,1));
        vecs.push_back(v(0,0,0,0,  0,1,0,1,  0,0,0,1,  1,0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i]);
            tick();
        end

        // fill and stall: rs1 tag 5 pending, ninth op refused
        for (int i = 0; i < 9; i++) begin
            drive(v(0,0,1,i, 5,0,0,1, 0,0,0,1, 0,0,0,0));
            #1;
            chk("fill_cnt", 96'(count_o), 96'((i < 8) ? i : 8));
            chk("fill_dr",  96'(disp_ready_o), 96'((i < 8) ? 1 : 0));
            chk("fill_iv",  96'(issue_valid_o), 96'(0));
            tick();
        end
        drive(v(0,0,0,0, 0,1,0,1, 2,0,5,1, 0,0,0,8));
        #1;
        check_out("wake", v(0,0,0,0, 0,1,0,1, 2,0,5,1, 0,0,0,8));
        tick();
        for (int i = 0; i < 8; i++) begin
            x = v(0,0,0,0, 0,1,0,1, 0,0,0,1, (i > 0) ? 1 : 0, 1, i, 8 - i);
            drive(x);
            #1;
            check_out($sformatf("drain%0d", i), x);
            tick();
        end
        x = v(0,0,0,0, 0,1,0,1, 0,0,0,1, 1,0,0,0);
        drive(x);
        #1;
        check_out("drained", x);
        tick();

        // sustained traffic past several age wraps against a FIFO model
        n = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            sz = q.size();
            dv = (cyc < 60) ? 1 : 0;
            ir = ((cyc % 3) != 2) ? 1 : 0;
            x = v(0,0,dv, n % 16, (n % 16) + 32, 1, (n % 16) + 64, 1, 0,0,0, ir,
                  (sz != 8) ? 1 : 0, (sz > 0) ? 1 : 0, (sz > 0) ? q[0] : 0, sz);
            drive(x);
            #1;
            check_out($sformatf("wrap%0d", cyc), x);
            if (sz > 0) begin
                chk("wrap_rs1", 96'(issue_rs1_tag_o), 96'(q[0] + 32));
                chk("wrap_rs2", 96'(issue_rs2_tag_o), 96'(q[0] + 64));
            end
            tick();
            acc = (dv == 1 && sz != 8) ? 1 : 0;
            if (ir == 1 && sz > 0) void'(q.pop_front());
            if (acc == 1) begin
                q.push_back(n % 16);
                n++;
            end
        end

        // flush with 5 entries while dispatching
        for (int i = 0; i < 5; i++) begin
            x = v(0,0,1,i, 0,1,0,1, 0,0,0,0, 1, (i > 0) ? 1 : 0, 0, i);
            drive(x);
            #1;
            check_out("ffill", x);
            tick();
        end
        x = v(0,1,1,9, 0,1,0,1, 0,0,0,1, 1,0,0,5);
        drive(x);
        #1;
        check_out("flush", x);
        tick();
        for (int k = 0; k < 3; k++) begin
            x = v(0,0,0,0, 0,1,0,1, 0,0,0,1, 1,0,0,0);
            drive(x);
            #1;
            check_out("post_flush", x);
            tick();
        end

        // reset asserted mid-drain
        for (int i = 1; i < 4; i++) begin
            x = v(0,0,1,i, 0,1,0,1, 0,0,0,0, 1, (i > 1) ? 1 : 0, 1, i - 1);
            drive(x);
            #1;
            check_out("rfill", x);
            tick();
        end
        x = v(0,0,0,0, 0,1,0,1, 0,0,0,1, 1,1,1,3);
        drive(x);
        #1;
        check_out("rdrain", x);
        tick();
        drive(v(1,1,1,12, 0,1,0,1, 3,0,0,1, 1,0,0,2));
        tick();
        #1;
        check_out("mid_rst", v(1,0,0,0, 0,0,0,0, 0,0,0,0, 1,0,0,0));
        check_reset_fields("mid_rst");
        tick();
        x = v(0,0,0,0, 0,1,0,1, 0,0,0,1, 1,0,0,0);
        drive(x);
        #1;
        check_out("after_rst", x);
        tick();
        check_out("after_rst2", x);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
